redundancy_voter: RTL and testbench

- Parametrised successor of the fixed three-hart bus voter. Sits between N lockstep cores and the system bus.
- Votes NCH packed request channels (e.g. instr, data) combinationally, so no bus latency is added.
- Tracks per-hart persistent faults with consecutive-mismatch counters and excludes faulty harts from the vote.
- Degrades NOMINAL -> DEGRADED -> FAILED, with registered error reporting and sticky status.

---
 rtl/redundancy_voter.sv | 205 ++++++++++++++++++++
 tb/tb_redundancy_voter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/redundancy_voter.sv
// Bitwise majority voter for N lockstep harts with per-hart fault
// disqualification, degradation state tracking and sticky error status.
module redundancy_voter #(
    parameter int unsigned NHARTS       = 3,
    parameter int unsigned NCH          = 2,
    parameter int unsigned W            = 72,
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic [NHARTS*NCH*W-1:0]    bus_i,
    output logic [NCH*W-1:0]           voted_o,
    output logic [NHARTS-1:0]          mismatch_o,
    output logic                       error_o,
    output logic [NHARTS-1:0]          error_id_o,
    output logic [NHARTS-1:0]          hart_fault_o,
    output logic                       uncorrectable_o,
    output logic [1:0]                 state_o,
    output logic [CNT_W-1:0]           err_cnt_o
);

    localparam int unsigned BW = NCH * W;
    localparam int unsigned CW = $clog2(FAULT_THRESH + 1);
    localparam int unsigned KW = $clog2(NHARTS + 1);
    localparam int unsigned LW = $clog2(NHARTS);

    typedef enum logic [1:0] {
        ST_NOMINAL  = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_FAILED   = 2'b10
    } state_e;

    logic [BW-1:0]       hart_bus [NHARTS];
    logic [NHARTS-1:0]   healthy;
    logic [KW-1:0]       k_cnt;
    logic [LW-1:0]       lo_idx;
    logic                lo_found;
    logic                multi;
    logic [KW-1:0]       ones;
    logic                tie_any;
    logic                no_majority;

    logic [CW-1:0]       cnt_q [NHARTS];
    logic [CW-1:0]       cnt_d [NHARTS];
    logic [NHARTS-1:0]   fault_q, fault_d;
    logic [NHARTS-1:0]   err_id_q, err_id_d;
    logic                error_q, error_d;
    logic                unc_q, unc_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    state_e              state_q, state_d;
    state_e              state_der;
    logic [KW-1:0]       k_next;

    // Split the flat bus into one word per hart (all channels of a hart are contiguous)
    always_comb begin
        for (int unsigned h = 0; h < NHARTS; h++) begin
            hart_bus[h] = bus_i[h*BW +: BW];
        end
    end

    // Healthy-set size and lowest-index healthy hart (hart 0 when none is healthy)
    always_comb begin
        healthy  = ~fault_q;
        k_cnt    = '0;
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int unsigned h = 0; h < NHARTS; h++) begin
            if (healthy[h]) begin
                k_cnt = k_cnt + KW'(1);
                if (!lo_found) begin
                    lo_idx   = LW'(h);
                    lo_found = 1'b1;
                end
            end
        end
        multi = (k_cnt >= KW'(2));
    end

    // Bitwise vote over healthy harts; ties fall back to the lowest healthy hart
    always_comb begin
        voted_o = '0;
        tie_any = 1'b0;
        ones    = '0;
        for (int unsigned b = 0; b < BW; b++) begin
            ones = '0;
            for (int unsigned h = 0; h < NHARTS; h++) begin
                if (healthy[h] && hart_bus[h][b]) begin
                    ones = ones + KW'(1);
                end
            end
            if (!multi) begin
                voted_o[b] = hart_bus[lo_idx][b];
            end else if ({ones, 1'b0} > {1'b0, k_cnt}) begin
                voted_o[b] = 1'b1;
            end else if ({ones, 1'b0} == {1'b0, k_cnt}) begin
                voted_o[b] = hart_bus[lo_idx][b];
                tie_any    = 1'b1;
            end else begin
                voted_o[b] = 1'b0;
            end
        end
        no_majority = multi && tie_any;
    end

    // Per-hart disagreement with the vote, healthy harts only
    always_comb begin
        mismatch_o = '0;
        for (int unsigned h = 0; h < NHARTS; h++) begin
            mismatch_o[h] = healthy[h] && multi && (hart_bus[h] != voted_o);
        end
    end

    // Next-state for counters, fault mask, sticky flags and degradation state
    always_comb begin
        for (int unsigned h = 0; h < NHARTS; h++) begin
            cnt_d[h] = cnt_q[h];
        end
        fault_d   = fault_q;
        err_id_d  = err_id_q;
        error_d   = 1'b0;
        unc_d     = unc_q;
        err_cnt_d = err_cnt_q;
        state_d   = state_q;
        state_der = ST_NOMINAL;
        k_next    = '0;

        if (clear_i) begin
            for (int unsigned h = 0; h < NHARTS; h++) begin
                cnt_d[h] = '0;
            end
            fault_d   = '0;
            err_id_d  = '0;
            unc_d     = 1'b0;
            err_cnt_d = '0;
            state_d   = ST_NOMINAL;
        end else if (enable_i) begin
            for (int unsigned h = 0; h < NHARTS; h++) begin
                if (fault_q[h] || !mismatch_o[h]) begin
                    cnt_d[h] = '0;
                end else if (cnt_q[h] == CW'(FAULT_THRESH - 1)) begin
                    cnt_d[h]   = '0;
                    fault_d[h] = 1'b1;
                end else begin
                    cnt_d[h] = cnt_q[h] + CW'(1);
                end
            end
            error_d  = |mismatch_o;
            err_id_d = err_id_q | mismatch_o;
            unc_d    = unc_q | no_majority;
            if (|mismatch_o && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end

            for (int unsigned h = 0; h < NHARTS; h++) begin
                if (!fault_d[h]) begin
                    k_next = k_next + KW'(1);
                end
            end
            if (k_next == KW'(NHARTS)) begin
                state_der = ST_NOMINAL;
            end else if (k_next >= KW'(2)) begin
                state_der = ST_DEGRADED;
            end else begin
                state_der = ST_FAILED;
            end
            state_d = (state_der > state_q) ? state_der : state_q;
        end
    end

    // Register bank with asynchronous active-high reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned h = 0; h < NHARTS; h++) begin
                cnt_q[h] <= '0;
            end
            fault_q   <= '0;
            err_id_q  <= '0;
            error_q   <= 1'b0;
            unc_q     <= 1'b0;
            err_cnt_q <= '0;
            state_q   <= ST_NOMINAL;
        end else begin
            for (int unsigned h = 0; h < NHARTS; h++) begin
                cnt_q[h] <= cnt_d[h];
            end
            fault_q   <= fault_d;
            err_id_q  <= err_id_d;
            error_q   <= error_d;
            unc_q     <= unc_d;
            err_cnt_q <= err_cnt_d;
            state_q   <= state_d;
        end
    end

    assign error_o         = error_q;
    assign error_id_o      = err_id_q;
    assign hart_fault_o    = fault_q;
    assign uncorrectable_o = unc_q;
    assign state_o         = state_q;
    assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_redundancy_voter.sv
// Scoreboard bench for redundancy_voter: a driver applies stimulus and pushes the
// reference model's expectation; a monitor pops and compares every cycle.
module tb_redundancy_voter;

    localparam int unsigned NH = 3;
    localparam int unsigned NC = 2;
    localparam int unsigned WW = 8;
    localparam int unsigned FT = 4;
    localparam int unsigned CWD = 4;
    localparam int unsigned ERRMAX = (1 << CWD) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               clr = 1'b0;
    logic [NH*NC*WW-1:0] bus = '0;
    logic [NC*WW-1:0]   voted;
    logic [NH-1:0]      mism;
    logic               err;
    logic [NH-1:0]      err_id;
    logic [NH-1:0]      fault;
    logic               unc;
    logic [1:0]         st;
    logic [CWD-1:0]     err_cnt;

    redundancy_voter #(
        .NHARTS(NH), .NCH(NC), .W(WW), .FAULT_THRESH(FT), .CNT_W(CWD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .bus_i(bus),
        .voted_o(voted), .mismatch_o(mism), .error_o(err), .error_id_o(err_id),
        .hart_fault_o(fault), .uncorrectable_o(unc), .state_o(st), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] voted;
        logic [2:0]  mism;
        logic        err;
        logic [2:0]  id;
        logic [2:0]  fault;
        logic        unc;
        logic [1:0]  st;
        logic [3:0]  errcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: words per hart/channel, integer counters and counts
    logic [7:0] mb [NH][NC];
    bit         m_fault [NH];
    int         m_cnt [NH];
    bit         m_err;
    logic [2:0] m_id;
    int         m_errcnt;
    bit         m_unc;
    int         m_st;

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_fault[h] = 0;
            m_cnt[h]   = 0;
        end
        m_err = 0; m_id = '0; m_errcnt = 0; m_unc = 0; m_st = 0;
    endtask

    // Majority per bit by counting ones among healthy harts
    task automatic model_comb(output logic [15:0] v, output logic [2:0] mm, output bit nomaj);
        int hl[$];
        int k;
        int ones;
        int src;
        for (int h = 0; h < NH; h++) if (!m_fault[h]) hl.push_back(h);
        k = hl.size();
        v = '0; mm = '0; nomaj = 0;
        for (int c = 0; c < NC; c++) begin
            for (int b = 0; b < WW; b++) begin
                if (k < 2) begin
                    src = (k == 0) ? 0 : hl[0];
                    v[c*WW+b] = mb[src][c][b];
                end else begin
                    ones = 0;
                    foreach (hl[i]) ones += int'(mb[hl[i]][c][b]);
                    if (2*ones > k) v[c*WW+b] = 1'b1;
                    else if (2*ones == k) begin
                        v[c*WW+b] = mb[hl[0]][c][b];
                        nomaj = 1;
                    end else v[c*WW+b] = 1'b0;
                end
            end
        end
        if (k >= 2) begin
            for (int h = 0; h < NH; h++) begin
                if (!m_fault[h] && (mb[h][0] != v[7:0] || mb[h][1] != v[15:8])) mm[h] = 1'b1;
            end
        end
    endtask

    // One cycle: drive at the falling edge, queue expectation, advance the model
    task automatic step(input bit e, input bit c, input bit r);
        logic [15:0] v;
        logic [2:0]  mm;
        bit          nomaj;
        exp_t        x;
        int          healthy_n;
        int          lvl;
        @(negedge clk);
        en = e; clr = c; rst = r;
        for (int h = 0; h < NH; h++)
            for (int ch = 0; ch < NC; ch++)
                bus[(h*NC+ch)*WW +: WW] = mb[h][ch];
        if (r) model_reset();
        model_comb(v, mm, nomaj);
        x.voted = v; x.mism = mm; x.err = m_err; x.id = m_id;
        x.fault = {m_fault[2], m_fault[1], m_fault[0]};
        x.unc = m_unc; x.st = 2'(m_st); x.errcnt = 4'(m_errcnt);
        exp_q.push_back(x);
        if (r) return;
        if (c) begin
            model_reset();
        end else if (e) begin
            for (int h = 0; h < NH; h++) begin
                if (!m_fault[h] && mm[h]) begin
                    m_cnt[h]++;
                    if (m_cnt[h] == FT) begin
                        m_fault[h] = 1;
                        m_cnt[h]   = 0;
                    end
                end else m_cnt[h] = 0;
            end
            m_err = |mm;
            m_id = m_id | mm;
            if (|mm && m_errcnt < ERRMAX) m_errcnt++;
            if (nomaj) m_unc = 1;
            healthy_n = 0;
            for (int h = 0; h < NH; h++) if (!m_fault[h]) healthy_n++;
            lvl = (healthy_n == NH) ? 0 : (healthy_n >= 2) ? 1 : 2;
            if (lvl > m_st) m_st = lvl;
        end else begin
            m_err = 0;
        end
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int h = 0; h < NH; h++)
            for (int c = 0; c < NC; c++) mb[h][c] = v;
    endtask

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endfunction

    // Monitor: every cycle the DUT presents a settled output set
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("voted",   32'(voted),   32'(x.voted));
                chk("mismatch",32'(mism),    32'(x.mism));
                chk("error",   32'(err),     32'(x.err));
                chk("error_id",32'(err_id),  32'(x.id));
                chk("fault",   32'(fault),   32'(x.fault));
                chk("uncorr",  32'(unc),     32'(x.unc));
                chk("state",   32'(st),      32'(x.st));
                chk("err_cnt", 32'(err_cnt), 32'(x.errcnt));
            end
        end
    end

    initial begin
        int r;
        logic [7:0] b0, b1;
        model_reset();
        set_all(8'hA5);
        step(0, 0, 1);
        step(0, 0, 1);
        // all agree
        repeat (3) step(1, 0, 0);
        // single transient mismatch on hart 1
        mb[1][0] = 8'h5A; step(1, 0, 0);
        set_all(8'hA5); repeat (2) step(1, 0, 0);
        // hart 2 persistent fault
        mb[2][1] = 8'h00; repeat (4) step(1, 0, 0);
        mb[2][0] = 8'h77; repeat (2) step(1, 0, 0);
        // tie in degraded mode
        for (int c = 0; c < NC; c++) begin
            mb[0][c] = 8'h0F; mb[1][c] = 8'hF0; mb[2][c] = 8'hC3;
        end
        step(1, 0, 0);
        set_all(8'hA5); repeat (2) step(1, 0, 0);
        // enable low holds, error drops
        mb[1][0] = 8'h01; step(0, 0, 0); step(0, 0, 0);
        set_all(8'hA5);
        // clear, then hart 0 outvoted by harts 1/2
        step(1, 1, 0);
        for (int c = 0; c < NC; c++) begin
            mb[0][c] = 8'hA5; mb[1][c] = 8'h33; mb[2][c] = 8'h33;
        end
        repeat (5) step(1, 0, 0);
        // harts 1 and 2 disagree: tie, hart 2 faulted -> FAILED
        for (int c = 0; c < NC; c++) begin
            mb[1][c] = 8'h11; mb[2][c] = 8'h22;
        end
        repeat (6) step(1, 0, 0);
        // async reset mid-operation
        step(1, 0, 1);
        set_all(8'h3C); step(1, 0, 0);
        // rotating mismatch to saturate err_cnt without faulting anyone
        for (int i = 0; i < (1 << CWD) + 3; i++) begin
            set_all(8'h3C);
            mb[i % NH][i % NC] = 8'hFF;
            step(1, 0, 0);
        end
        set_all(8'h3C); step(1, 0, 0);
        step(1, 1, 0); step(1, 0, 0);
        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            b0 = 8'($urandom); b1 = 8'($urandom);
            for (int h = 0; h < NH; h++) begin
                mb[h][0] = b0; mb[h][1] = b1;
                if ($urandom_range(0, 5) == 0)
                    mb[h][$urandom_range(0, 1)] ^= 8'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 2);
                mb[(r + 1) % NH][0] = mb[r][0];
                mb[(r + 1) % NH][1] = mb[r][1];
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 249) == 0);
        end
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
